// File: rtl/mem_rmw_seq.sv
// rtl/mem_rmw_seq.sv - Multi-cycle load/store sequencer with sub-word read-modify-write
module mem_rmw_seq #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iREQ_VALID,
    output logic              oREQ_READY,
    input  logic              iREQ_WE,
    input  logic [2:0]        iREQ_FUNC3,
    input  logic [31:0]       iREQ_ADDR,
    input  logic [31:0]       iREQ_WDATA,
    output logic              oRSP_VALID,
    output logic [31:0]       oRSP_RDATA,
    output logic              oRSP_ERR,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    input  logic [31:0]       iRAM_DATA,
    output logic [31:0]       oRAM_DATA
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // The latency counter runs RD_LAT-1 down to 0; zero marks the capture edge.
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t              state_q;
    logic                ready_q;
    logic                ram_ce_q;
    logic                ram_rd_q;
    logic                ram_wr_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [31:0]         ram_wdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [31:0]         rsp_rdata_q;
    logic [1:0]          lat_q;
    logic                we_q;
    logic [2:0]          func3_q;
    logic [1:0]          lane_q;
    logic [31:0]         wdata_q;

    logic                req_illegal;
    logic                req_misaligned;
    logic                req_is_sw;
    logic                unused_addr_hi;

    // Upper address bits wrap inside the RAM space and are intentionally dropped.
    assign unused_addr_hi = ^iREQ_ADDR[31:ADDR_W+2];

    // Request decode at the accept edge: illegal funct3, misalignment, full-word store.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (iREQ_WE) begin
            req_illegal = (iREQ_FUNC3 > 3'd2);
        end else begin
            req_illegal = (iREQ_FUNC3 == 3'd3) || (iREQ_FUNC3 == 3'd6) || (iREQ_FUNC3 == 3'd7);
        end
        if (iREQ_FUNC3[1:0] == 2'd1) begin
            req_misaligned = iREQ_ADDR[0];
        end else if (iREQ_FUNC3[1:0] == 2'd2) begin
            req_misaligned = (iREQ_ADDR[1:0] != 2'd0);
        end
        req_is_sw = iREQ_WE && (iREQ_FUNC3 == 3'd2);
    end

    // Merge store data into the word read back from RAM (SB/SH); SW replaces it.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  func3,
                                                input logic [1:0]  lane);
        logic [31:0] word;
        word = old_word;
        case (func3[1:0])
            2'd0:    word[{lane, 3'b000} +: 8] = wdata[7:0];
            2'd1:    begin
                if (lane[1]) begin
                    word[31:16] = wdata[15:0];
                end else begin
                    word[15:0] = wdata[15:0];
                end
            end
            default: word = wdata;
        endcase
        return word;
    endfunction

    // Pick the addressed lane out of the RAM word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  func3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (func3)
            3'd0:    result = {{24{b[7]}}, b};
            3'd1:    result = {{16{h[15]}}, h};
            3'd4:    result = {24'd0, b};
            3'd5:    result = {16'd0, h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Sequencer FSM; every RAM strobe and response output is a register here.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            lat_q       <= '0;
            we_q        <= 1'b0;
            func3_q     <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (iREQ_VALID && ready_q) begin
                        ready_q    <= 1'b0;
                        we_q       <= iREQ_WE;
                        func3_q    <= iREQ_FUNC3;
                        lane_q     <= iREQ_ADDR[1:0];
                        wdata_q    <= iREQ_WDATA;
                        ram_addr_q <= iREQ_ADDR[ADDR_W+1:2];
                        if (req_illegal || req_misaligned) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (req_is_sw) begin
                            state_q     <= S_WRITE;
                            ram_ce_q    <= 1'b1;
                            ram_wr_q    <= 1'b1;
                            ram_wdata_q <= iREQ_WDATA;
                        end else begin
                            state_q  <= S_READ;
                            ram_ce_q <= 1'b1;
                            ram_rd_q <= 1'b1;
                            lat_q    <= LAT_INIT;
                        end
                    end
                end
                S_READ: begin
                    if (lat_q == 2'd0) begin
                        ram_rd_q <= 1'b0;
                        if (we_q) begin
                            state_q     <= S_WRITE;
                            ram_wr_q    <= 1'b1;
                            ram_wdata_q <= merge_store(iRAM_DATA, wdata_q, func3_q, lane_q);
                        end else begin
                            state_q     <= S_RESP;
                            ram_ce_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= load_extend(iRAM_DATA, func3_q, lane_q);
                        end
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                S_WRITE: begin
                    state_q     <= S_RESP;
                    ram_ce_q    <= 1'b0;
                    ram_wr_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oREQ_READY = ready_q;
    assign oRSP_VALID = rsp_valid_q;
    assign oRSP_RDATA = rsp_rdata_q;
    assign oRSP_ERR   = rsp_err_q;
    assign oRAM_CE    = ram_ce_q;
    assign oRAM_RD    = ram_rd_q;
    assign oRAM_WR    = ram_wr_q;
    assign oRAM_ADDR  = ram_addr_q;
    assign oRAM_DATA  = ram_wdata_q;

endmodule

// File: tb/tb_mem_rmw_seq.sv
// tb/tb_mem_rmw_seq.sv - Randomized self-checking bench for mem_rmw_seq (RD_LAT 1 and 3)
module tb_mem_rmw_seq;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n      [2];
    logic              req_valid  [2];
    logic              req_ready  [2];
    logic              req_we     [2];
    logic [2:0]        req_func3  [2];
    logic [31:0]       req_addr   [2];
    logic [31:0]       req_wdata  [2];
    logic              rsp_valid  [2];
    logic [31:0]       rsp_rdata  [2];
    logic              rsp_err    [2];
    logic              ram_ce     [2];
    logic              ram_rd     [2];
    logic              ram_wr     [2];
    logic [ADDR_W-1:0] ram_addr   [2];
    logic [31:0]       ram_rdata  [2];
    logic [31:0]       ram_wdata  [2];

    logic              pre_we     [2];
    logic [7:0]        pre_addr   [2];
    logic [31:0]       pre_data   [2];

    logic [31:0]       ref_mem    [2][256];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3; each has its own RAM model.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [256];
        int          rd_run = 0;

        mem_rmw_seq #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) u_dut (
            .iCLK       (clk),
            .iRST_N     (rst_n[g]),
            .iREQ_VALID (req_valid[g]),
            .oREQ_READY (req_ready[g]),
            .iREQ_WE    (req_we[g]),
            .iREQ_FUNC3 (req_func3[g]),
            .iREQ_ADDR  (req_addr[g]),
            .iREQ_WDATA (req_wdata[g]),
            .oRSP_VALID (rsp_valid[g]),
            .oRSP_RDATA (rsp_rdata[g]),
            .oRSP_ERR   (rsp_err[g]),
            .oRAM_CE    (ram_ce[g]),
            .oRAM_RD    (ram_rd[g]),
            .oRAM_WR    (ram_wr[g]),
            .oRAM_ADDR  (ram_addr[g]),
            .iRAM_DATA  (ram_rdata[g]),
            .oRAM_DATA  (ram_wdata[g])
        );

        // RAM: data is only valid once RD has been held for LAT cycles.
        always_ff @(posedge clk) begin
            if (pre_we[g]) begin
                mem[pre_addr[g]] <= pre_data[g];
            end else if (ram_ce[g] && ram_wr[g]) begin
                mem[ram_addr[g]] <= ram_wdata[g];
            end
            if (ram_ce[g] && ram_rd[g]) begin
                rd_run <= rd_run + 1;
            end else begin
                rd_run <= 0;
            end
        end

        assign ram_rdata[g] = (ram_ce[g] && ram_rd[g] && (rd_run == LAT - 1)) ? mem[ram_addr[g]] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input bit we, input int f3, input logic [31:0] a);
        int sz;
        sz = f3 % 4;
        if (we && f3 > 2) return 1'b1;
        if (!we && (f3 == 3 || f3 >= 6)) return 1'b1;
        if (sz == 1 && (a % 2) != 0) return 1'b1;
        if (sz == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input int f3, input logic [31:0] a);
        logic [31:0] sh;
        sh = word >> (8 * (a % 4));
        case (f3)
            0:       return 32'($signed(sh[7:0]));
            1:       return 32'($signed(sh[15:0]));
            4:       return sh & 32'hFF;
            5:       return sh & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input int f3,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (f3 == 2) return wd;
        mask = (f3 == 0) ? 32'hFF : 32'hFFFF;
        sh   = 8 * (a % 4);
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic preload(input int idx, input int wa, input logic [31:0] d);
        pre_we[idx]   = 1'b1;
        pre_addr[idx] = 8'(wa);
        pre_data[idx] = d;
        @(negedge clk);
        pre_we[idx]   = 1'b0;
        ref_mem[idx][wa] = d;
    endtask

    // Issue one request at a negedge with READY high, then watch the strobes cycle by cycle.
    task automatic txn(input int idx, input string nm, input bit we, input int f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input bit nwe, input int nf3,
                       input logic [31:0] na, input logic [31:0] nwd);
        int          lat;
        int          wi;
        bit          e;
        bit          sw;
        int          exp_rd, exp_wr_k, exp_rsp_k;
        logic [31:0] exp_wdata, exp_rdata;
        int          rd_n, rd_first, wr_n, wr_k, ce_n, rsp_k, busy_rdy, addr_bad;
        logic [31:0] wr_d, rsp_d;
        logic        rsp_e;
        lat       = (idx == 0) ? 1 : 3;
        wi        = int'((a / 4) % 256);
        e         = model_err(we, f3, a);
        sw        = we && (f3 == 2);
        exp_rd    = (e || sw) ? 0 : lat;
        exp_wr_k  = e ? 0 : (sw ? 1 : (we ? lat + 1 : 0));
        exp_rsp_k = e ? 1 : (sw ? 2 : (we ? lat + 2 : lat + 1));
        exp_wdata = we ? model_store(ref_mem[idx][wi], f3, a, wd) : 32'd0;
        exp_rdata = (e || we) ? 32'd0 : model_load(ref_mem[idx][wi], f3, a);
        rd_n = 0; rd_first = 0; wr_n = 0; wr_k = 0; ce_n = 0; rsp_k = 0; busy_rdy = 0; addr_bad = 0;
        wr_d = 0; rsp_d = 0; rsp_e = 0;

        req_we[idx]    = we;
        req_func3[idx] = 3'(f3);
        req_addr[idx]  = a;
        req_wdata[idx] = wd;
        req_valid[idx] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    req_we[idx]    = nwe;
                    req_func3[idx] = 3'(nf3);
                    req_addr[idx]  = na;
                    req_wdata[idx] = nwd;
                end else begin
                    req_valid[idx] = 1'b0;
                end
            end
            if (ram_ce[idx]) ce_n++;
            if (ram_ce[idx] && ram_rd[idx]) begin
                rd_n++;
                if (rd_first == 0) rd_first = k;
                if (ram_addr[idx] != 8'(wi)) addr_bad++;
            end
            if (ram_ce[idx] && ram_wr[idx]) begin
                wr_n++;
                wr_k = k;
                wr_d = ram_wdata[idx];
                if (ram_addr[idx] != 8'(wi)) addr_bad++;
            end
            if (req_ready[idx]) busy_rdy++;
            if (rsp_valid[idx]) begin
                rsp_k = k;
                rsp_d = rsp_rdata[idx];
                rsp_e = rsp_err[idx];
                break;
            end
        end

        check({nm, "/rsp_cycle"}, rsp_k, exp_rsp_k);
        check({nm, "/rsp_err"}, {31'd0, rsp_e}, {31'd0, e});
        check({nm, "/rsp_rdata"}, rsp_d, exp_rdata);
        check({nm, "/rd_cycles"}, rd_n, exp_rd);
        if (exp_rd != 0) check({nm, "/rd_first"}, rd_first, 1);
        check({nm, "/wr_count"}, wr_n, (exp_wr_k != 0) ? 1 : 0);
        if (exp_wr_k != 0) begin
            check({nm, "/wr_cycle"}, wr_k, exp_wr_k);
            check({nm, "/wr_data"}, wr_d, exp_wdata);
        end
        check({nm, "/ram_addr"}, addr_bad, 0);
        if (e) check({nm, "/ce_on_err"}, ce_n, 0);
        check({nm, "/ready_busy"}, busy_rdy, 0);
        if (we && !e) ref_mem[idx][wi] = exp_wdata;

        @(negedge clk);
        check({nm, "/ready_idle"}, {31'd0, req_ready[idx]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_seen, rsp_seen, rdy_seen;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_func3[i] = '0;
            req_addr[i] = '0; req_wdata[i] = '0; pre_we[i] = 1'b0; pre_addr[i] = '0; pre_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d/ready", i), {31'd0, req_ready[i]}, 32'd0);
            check($sformatf("reset%0d/rsp_valid", i), {31'd0, rsp_valid[i]}, 32'd0);
            check($sformatf("reset%0d/rsp_err", i), {31'd0, rsp_err[i]}, 32'd0);
            check($sformatf("reset%0d/rsp_rdata", i), rsp_rdata[i], 32'd0);
            check($sformatf("reset%0d/strobes", i), {29'd0, ram_ce[i], ram_rd[i], ram_wr[i]}, 32'd0);
            check($sformatf("reset%0d/ram_data", i), ram_wdata[i], 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 16; w++) preload(i, w, $urandom);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("release/ready0", {31'd0, req_ready[0]}, 32'd1);
        check("release/ready1", {31'd0, req_ready[1]}, 32'd1);

        preload(0, 4, 32'h1122_3344);
        txn(0, "t1_sb", 1, 0, 32'h11, 32'hAA, 0, 0, 0, 0, 0);
        check("t1/ram_word", g_dut[0].mem[4], 32'h1122_AA44);

        preload(0, 4, 32'h1122_3344);
        txn(0, "t2_sh", 1, 1, 32'h12, 32'hBEEF, 0, 0, 0, 0, 0);
        check("t2/ram_word_sh", g_dut[0].mem[4], 32'hBEEF_3344);
        txn(0, "t2_sw", 1, 2, 32'h10, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        check("t2/ram_word_sw", g_dut[0].mem[4], 32'hCAFE_F00D);

        preload(0, 4, 32'h80FF_1234);
        txn(0, "t3_lb",  0, 0, 32'h13, 0, 0, 0, 0, 0, 0);
        txn(0, "t3_lbu", 0, 4, 32'h13, 0, 0, 0, 0, 0, 0);
        txn(0, "t3_lh",  0, 1, 32'h12, 0, 0, 0, 0, 0, 0);
        txn(0, "t3_lw",  0, 2, 32'h10, 0, 0, 0, 0, 0, 0);

        txn(0, "t4_sw_mis", 1, 2, 32'h06, 32'h1234_5678, 0, 0, 0, 0, 0);
        txn(0, "t4_lh_mis", 0, 1, 32'h11, 0, 0, 0, 0, 0, 0);
        txn(0, "t4_ld_f3",  0, 3, 32'h10, 0, 0, 0, 0, 0, 0);

        preload(0, 4, 32'h1122_3344);
        req_we[0] = 1'b1; req_func3[0] = 3'd0; req_addr[0] = 32'h11; req_wdata[0] = 32'hAA;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("t5/in_read", {31'd0, ram_rd[0]}, 32'd1);
        rst_n[0] = 1'b0;
        wr_seen = 0; rsp_seen = 0; rdy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ram_wr[0]) wr_seen++;
            if (rsp_valid[0]) rsp_seen++;
            if (req_ready[0]) rdy_seen++;
        end
        rst_n[0] = 1'b1;
        @(negedge clk);
        if (ram_wr[0]) wr_seen++;
        if (rsp_valid[0]) rsp_seen++;
        check("t5/no_wr", wr_seen, 0);
        check("t5/no_rsp", rsp_seen, 0);
        check("t5/ready_in_reset", rdy_seen, 0);
        check("t5/ready_after", {31'd0, req_ready[0]}, 32'd1);
        check("t5/ram_word", g_dut[0].mem[4], 32'h1122_3344);
        txn(0, "t5_lw", 0, 2, 32'h10, 0, 0, 0, 0, 0, 0);

        preload(1, 2, 32'h0BAD_F00D);
        preload(1, 3, 32'h7654_3210);
        txn(1, "t6_lw_a", 0, 2, 32'h08, 0, 1, 0, 2, 32'h0C, 0);
        txn(1, "t6_lw_b", 0, 2, 32'h0C, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
            txn(n % 2, $sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                a, $urandom, 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
